// File: rtl/eth_mac_pkg.sv
// ---------------------------------------------------------------------------
// eth_mac_pkg
// Shared constants, the TX framer state encoding and a byte-wide reflected
// CRC-32 step function used by the Ethernet TX path.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package eth_mac_pkg;

    localparam logic [7:0]  ETH_PREAMBLE   = 8'h55;
    localparam logic [7:0]  ETH_SFD        = 8'hD5;
    localparam logic [31:0] CRC32_POLY_REF = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT     = 32'hFFFFFFFF;

    // Payload length counter width; saturates at 2047.
    localparam int LEN_W = 11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_IFG
    } tx_state_t;

    // One byte of the LSB-first (reflected) CRC-32 update.
    function automatic logic [31:0] crc32_d8(input logic [31:0] crc,
                                             input logic [7:0]  data);
        logic [31:0] c;
        c = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REF) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_d8_gen.sv
// ---------------------------------------------------------------------------
// crc32_d8_gen
// Running CRC-32 register, one byte per enabled clock.
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset (register -> CRC32_INIT)
//   init   in   reload CRC32_INIT (has priority over en)
//   en     in   fold data into the running CRC this clock
//   data   in   8-bit byte to fold
//   crc_o  out  32-bit running CRC (not inverted)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module crc32_d8_gen
    import eth_mac_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc_o
);

    logic [31:0] r_crc;
    logic [31:0] w_crc_next;

    assign w_crc_next = crc32_d8(r_crc, data);
    assign crc_o      = r_crc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc <= CRC32_INIT;
        end else if (init) begin
            r_crc <= CRC32_INIT;
        end else if (en) begin
            r_crc <= w_crc_next;
        end
    end

endmodule

// File: rtl/eth_tx_framer.sv
// ---------------------------------------------------------------------------
// eth_tx_framer
// Wraps a byte/valid/ack payload stream into a GMII-style frame:
// preamble, SFD, payload, zero pad to the minimum size, CRC-32 FCS and an
// inter-frame gap.
// Ports:
//   clk          in   TX clock
//   rst_n        in   asynchronous active-low reset
//   s_data_i     in   8   payload byte
//   s_valid_i    in   1   high for the whole payload, low ends it
//   s_ack_o      out  1   s_data_i consumed this clock (combinational)
//   txd_o        out  8   line byte (registered)
//   tx_en_o      out  1   line byte valid (registered)
//   tx_er_o      out  1   high on FCS bytes of an oversize frame (registered)
//   frame_cnt_o  out  16  completed frames, wrapping
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module eth_tx_framer
    import eth_mac_pkg::*;
#(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_PAYLOAD  = 60,
    parameter int MAX_PAYLOAD  = 1514,
    parameter int IFG_CYCLES   = 12
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_data_i,
    input  logic        s_valid_i,
    output logic        s_ack_o,
    output logic [7:0]  txd_o,
    output logic        tx_en_o,
    output logic        tx_er_o,
    output logic [15:0] frame_cnt_o
);

    localparam logic [7:0]       PRE_LAST = 8'(PREAMBLE_LEN - 1);
    localparam logic [7:0]       IFG_LAST = 8'(IFG_CYCLES - 1);
    localparam logic [LEN_W-1:0] MIN_LEN  = LEN_W'(MIN_PAYLOAD);
    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_PAYLOAD);
    localparam logic [LEN_W-1:0] LEN_SAT  = '1;

    tx_state_t        r_state;
    tx_state_t        w_state_next;
    logic [7:0]       r_cnt;
    logic [LEN_W-1:0] r_len;
    logic             r_ovf;
    logic [7:0]       r_txd;
    logic             r_tx_en;
    logic             r_tx_er;
    logic [15:0]      r_frame_cnt;

    logic [7:0]       w_txd_next;
    logic             w_tx_en_next;
    logic             w_tx_er_next;
    logic             w_ack;
    logic             w_crc_init;
    logic             w_crc_en;
    logic [7:0]       w_crc_data;
    logic             w_len_inc;
    logic             w_ovf_set;
    logic             w_frame_done;
    logic [31:0]      w_crc;
    logic             w_len_short;
    logic             w_len_full;
    logic [7:0]       w_fcs_byte [4];

    // ------------------------------------------------------------------
    // CRC engine: re-armed every IDLE cycle so each frame starts clean.
    // ------------------------------------------------------------------
    crc32_d8_gen u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .init  (w_crc_init),
        .en    (w_crc_en),
        .data  (w_crc_data),
        .crc_o (w_crc)
    );

    // FCS is the complemented CRC, transmitted least significant byte first.
    for (genvar gi = 0; gi < 4; gi++) begin : g_fcs
        assign w_fcs_byte[gi] = ~w_crc[8*gi +: 8];
    end

    // With no minimum size there is never anything to pad.
    if (MIN_PAYLOAD == 0) begin : g_no_pad
        assign w_len_short = 1'b0;
    end else begin : g_pad
        assign w_len_short = (r_len < MIN_LEN);
    end

    // Bytes beyond the maximum are still acked so the sender drains.
    assign w_len_full = (r_len >= MAX_LEN);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (s_valid_i) w_state_next = ST_PRE;
            ST_PRE:  if (r_cnt == PRE_LAST) w_state_next = ST_SFD;
            ST_SFD, ST_DATA: begin
                if (s_valid_i)        w_state_next = ST_DATA;
                else if (w_len_short) w_state_next = ST_PAD;
                else                  w_state_next = ST_FCS;
            end
            ST_PAD:  if (!w_len_short) w_state_next = ST_FCS;
            ST_FCS:  if (r_cnt[1:0] == 2'd3) w_state_next = ST_IFG;
            ST_IFG:  if (r_cnt == IFG_LAST) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. "next" values are what the line shows one clock later.
    // ------------------------------------------------------------------
    always_comb begin
        w_txd_next   = r_txd;
        w_tx_en_next = r_tx_en;
        w_tx_er_next = r_tx_er;
        w_ack        = 1'b0;
        w_crc_init   = 1'b0;
        w_crc_en     = 1'b0;
        w_crc_data   = s_data_i;
        w_len_inc    = 1'b0;
        w_ovf_set    = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_crc_init   = 1'b1;
                w_txd_next   = 8'h00;
                w_tx_en_next = 1'b0;
                w_tx_er_next = 1'b0;
                if (s_valid_i) begin
                    w_txd_next   = ETH_PREAMBLE;
                    w_tx_en_next = 1'b1;
                end
            end
            ST_PRE: begin
                w_txd_next = (r_cnt == PRE_LAST) ? ETH_SFD : ETH_PREAMBLE;
            end
            ST_SFD, ST_DATA: begin
                if (s_valid_i) begin
                    w_ack     = 1'b1;
                    w_len_inc = 1'b1;
                    if (w_len_full) begin
                        // Oversize: swallow the byte, the line holds its prior value.
                        w_ovf_set = 1'b1;
                    end else begin
                        w_txd_next = s_data_i;
                        w_crc_en   = 1'b1;
                    end
                end else if (w_len_short) begin
                    w_txd_next = 8'h00;
                    w_crc_data = 8'h00;
                    w_crc_en   = 1'b1;
                    w_len_inc  = 1'b1;
                end else begin
                    w_txd_next   = w_fcs_byte[0];
                    w_tx_er_next = r_ovf;
                end
            end
            ST_PAD: begin
                if (w_len_short) begin
                    w_txd_next = 8'h00;
                    w_crc_data = 8'h00;
                    w_crc_en   = 1'b1;
                    w_len_inc  = 1'b1;
                end else begin
                    w_txd_next   = w_fcs_byte[0];
                    w_tx_er_next = r_ovf;
                end
            end
            ST_FCS: begin
                if (r_cnt[1:0] == 2'd3) begin
                    w_txd_next   = 8'h00;
                    w_tx_en_next = 1'b0;
                    w_tx_er_next = 1'b0;
                    w_frame_done = 1'b1;
                end else begin
                    w_txd_next = w_fcs_byte[2'(r_cnt[1:0] + 2'd1)];
                end
            end
            ST_IFG: begin
                w_txd_next   = 8'h00;
                w_tx_en_next = 1'b0;
                w_tx_er_next = 1'b0;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_len       <= '0;
            r_ovf       <= 1'b0;
            r_txd       <= 8'h00;
            r_tx_en     <= 1'b0;
            r_tx_er     <= 1'b0;
            r_frame_cnt <= 16'h0000;
        end else begin
            // Per-state cycle counter restarts on every state change.
            r_cnt <= (w_state_next != r_state) ? 8'h00 : r_cnt + 8'd1;

            if (r_state == ST_IDLE) begin
                r_len <= '0;
            end else if (w_len_inc && (r_len != LEN_SAT)) begin
                r_len <= r_len + 1'b1;
            end

            if (r_state == ST_IDLE) begin
                r_ovf <= 1'b0;
            end else if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end

            r_txd   <= w_txd_next;
            r_tx_en <= w_tx_en_next;
            r_tx_er <= w_tx_er_next;

            if (w_frame_done) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    assign s_ack_o     = w_ack;
    assign txd_o       = r_txd;
    assign tx_en_o     = r_tx_en;
    assign tx_er_o     = r_tx_er;
    assign frame_cnt_o = r_frame_cnt;

endmodule
